click_sequencer: RTL
====================

Name: click_sequencer

Overview:
- Front-end controller for the minesweeper button datapath.
- Synchronises and debounces the five raw buttons (C/U/R/D/L).
- Resolves single vs double centre clicks using a timed window.
- Issues one 3-bit action code at a time to game logic and holds it until acknowledged.

Parameters:
- DEB_CYCLES, 16'd50000, number of consecutive stable synchronised samples required to accept a button level change (must be >= 1).
- DBL_WINDOW, 24'd5000000, cycles after the first centre press during which a second centre press counts as a double click (must be >= 2).
- CNT_W, 24, width of the debounce and window counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- btn_c  in  1  raw centre button, asynchronous.
- btn_u  in  1  raw up button, asynchronous.
- btn_r  in  1  raw right button, asynchronous.
- btn_d  in  1  raw down button, asynchronous.
- btn_l  in  1  raw left button, asynchronous.
- dbl_sw  in  1  runtime double-click enable (switch); sampled in IDLE only.
- ack  in  1  consumer accepts the current action.
- action  out  3  action code: 000 none, 001 single C, 010 double C, 100 U, 101 R, 110 D, 111 L.
- action_valid  out  1  action holds a pending code.
- overrun  out  1  one-cycle pulse when a press event is dropped.

Behaviour:
- Reset (clear_n=0, async): sync flops, stable vector, counters = 0; state IDLE; action=000; action_valid=0; overrun=0.
- Synchroniser: 2 flops per button, bundled as a 5-bit vector.
- Debounce: one shared counter.
  - Synced vector differs from last sample: counter clears.
  - Otherwise counter increments, saturating at DEB_CYCLES-1.
  - On the cycle the counter equals DEB_CYCLES-1, the stable vector loads the synced vector.
- Press event: rising edge of a stable bit, one cycle wide.
- Latency: a clean raw step produces a stable rise 2+DEB_CYCLES edges after first capture; action_valid rises on the next edge.
- Simultaneous direction events: priority U > R > D > L. Lower-priority simultaneous direction events are dropped silently, with no overrun.
- FSM states: IDLE, C_WAIT, PEND.
- IDLE:
  - C event with dbl_sw=1: go to C_WAIT, window counter = 0.
  - C event with dbl_sw=0: go to PEND, action=001.
  - Direction event (no C event): go to PEND with its code.
  - C event outranks same-cycle direction events; those are dropped, overrun pulses.
- C_WAIT: window counter increments each cycle.
  - C event while counter < DBL_WINDOW-1: go to PEND, action=010.
  - Counter reaches DBL_WINDOW-1 with no C event: go to PEND, action=001.
  - C event on the same cycle as the terminal count: double (010) wins.
  - Direction event: go to PEND with 001; direction dropped, overrun pulses.
- PEND:
  - action_valid=1; action held stable.
  - ack=1: go to IDLE on that edge; action returns to 000 and action_valid to 0.
  - Any press event while in PEND, including the ack cycle: dropped, overrun pulses.
- Outside PEND: action=000, action_valid=0.
- Counters never wrap: the window counter stops at DBL_WINDOW-1; the debounce counter saturates.
- Reset mid-operation: everything returns to the reset values immediately; a pending action is lost.

Optional Feature:
- Macro: CLICK_DOUBLE_EN.
- Defined: double-click path present as described; dbl_sw honoured.
- Undefined:
  - No C_WAIT state and no window counter logic; DBL_WINDOW unused.
  - dbl_sw ignored; every C event goes directly to PEND with 001.
  - Code 010 is never produced.

Test Plan (DEB_CYCLES=4, DBL_WINDOW=20, CLICK_DOUBLE_EN defined):
- Reset check: hold clear_n=0, toggle buttons, release reset -> action=000, action_valid=0, overrun=0.
- Single direction: btn_r high for 10 cycles -> action_valid rises exactly 7 edges after first capture, action=101; hold ack=0 for 5 cycles -> action held; pulse ack=1 -> next edge action=000, action_valid=0.
- Bounce rejection: btn_u toggled every 2 cycles for 12 cycles, then held high -> exactly one action=100 after the stable period; no overrun.
- Double click: dbl_sw=1; press C, release, press C again, the second stable rise 10 cycles after the first -> single action=010. With the second rise 25 cycles after the first -> action=001 appears 20 cycles after the first event, and the second press is handled as a new click sequence.
- Direction during window: dbl_sw=1, C event then btn_l event 5 cycles later -> action=001, overrun pulses once, no 111 issued.
- Overrun in PEND and priority: btn_u and btn_d rise together -> action=100, no overrun; with ack held 0, a btn_l event -> overrun=1 for one cycle, action stays 100.

Source files
------------

// File: rtl/click_sequencer.sv
// Button front-end: 2-flop synchronisers, shared-counter debounce, centre single/double click
// resolution and a one-deep action register. Define CLICK_DOUBLE_EN to build the double-click window.
module click_sequencer #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [23:0] DBL_WINDOW = 24'd5000000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_r,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       dbl_sw,
    input  logic       ack,
    output logic [2:0] action,
    output logic       action_valid,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 16'd1);

`ifdef CLICK_DOUBLE_EN
    localparam logic [CNT_W-1:0] DBL_MAX = CNT_W'(DBL_WINDOW - 24'd1);
    typedef enum logic [1:0] {IDLE, C_WAIT, PEND} state_t;
    logic [CNT_W-1:0] win_cnt;
`else
    typedef enum logic [1:0] {IDLE, PEND} state_t;
    logic unused_dbl;
    assign unused_dbl = dbl_sw ^ DBL_WINDOW[0];
`endif

    state_t state;

    // Bit order: 0=C, 1=U, 2=R, 3=D, 4=L
    logic [4:0]       raw, sync1, sync2, last, stable, stable_q, rise;
    logic [CNT_W-1:0] deb_cnt;
    logic             differ;
    logic             ev_c, ev_dir;
    logic [2:0]       dir_code;

    assign raw    = {btn_l, btn_d, btn_r, btn_u, btn_c};
    assign differ = (sync2 != last);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1    <= '0;
            sync2    <= '0;
            last     <= '0;
            stable   <= '0;
            stable_q <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            last     <= sync2;
            stable_q <= stable;
            if (differ) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
            // Load only once the counter has saturated and this sample still agrees
            if (!differ && deb_cnt == DEB_MAX) begin
                stable <= sync2;
            end
        end
    end

    assign rise   = stable & ~stable_q;
    assign ev_c   = rise[0];
    assign ev_dir = |rise[4:1];

    always_comb begin
        dir_code = 3'b000;
        if (rise[1])      dir_code = 3'b100;
        else if (rise[2]) dir_code = 3'b101;
        else if (rise[3]) dir_code = 3'b110;
        else if (rise[4]) dir_code = 3'b111;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state        <= IDLE;
            action       <= '0;
            action_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef CLICK_DOUBLE_EN
            win_cnt      <= '0;
`endif
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_c) begin
                        overrun <= ev_dir;
`ifdef CLICK_DOUBLE_EN
                        if (dbl_sw) begin
                            state   <= C_WAIT;
                            win_cnt <= '0;
                        end else begin
                            state        <= PEND;
                            action       <= 3'b001;
                            action_valid <= 1'b1;
                        end
`else
                        state        <= PEND;
                        action       <= 3'b001;
                        action_valid <= 1'b1;
`endif
                    end else if (ev_dir) begin
                        state        <= PEND;
                        action       <= dir_code;
                        action_valid <= 1'b1;
                    end
                end
`ifdef CLICK_DOUBLE_EN
                C_WAIT: begin
                    // A second C wins even on the terminal-count cycle
                    if (ev_c) begin
                        state        <= PEND;
                        action       <= 3'b010;
                        action_valid <= 1'b1;
                        overrun      <= ev_dir;
                    end else if (ev_dir || win_cnt == DBL_MAX) begin
                        state        <= PEND;
                        action       <= 3'b001;
                        action_valid <= 1'b1;
                        overrun      <= ev_dir;
                    end else begin
                        win_cnt <= win_cnt + CNT_W'(1);
                    end
                end
`endif
                PEND: begin
                    overrun <= ev_c | ev_dir;
                    if (ack) begin
                        state        <= IDLE;
                        action       <= '0;
                        action_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    action       <= '0;
                    action_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
